// File: rtl/adiabatic_pclk_seq_if.sv
// Handshake and power-clock bundle between the adiabatic phase sequencer and
// the surrounding digital logic.
interface adiabatic_pclk_seq_if #(
    parameter int NSTAGE = 4
);
    logic              en;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              busy;
    logic [NSTAGE-1:0] pc_up;
    logic [NSTAGE-1:0] pc_hold;
    logic [NSTAGE-1:0] pc_dn;

    // master = surrounding digital logic, slave = the sequencer itself
    modport master (
        output en, in_valid,
        input  in_ready, out_valid, busy, pc_up, pc_hold, pc_dn
    );

    modport slave (
        input  en, in_valid,
        output in_ready, out_valid, busy, pc_up, pc_hold, pc_dn
    );
endinterface

// File: rtl/adiabatic_pclk_seq.sv
// Four-phase power-clock sequencer for an NSTAGE adiabatic pipeline: orderly
// fill/drain of stage gates, token tagging and launch/capture handshake.
module adiabatic_pclk_seq #(
    parameter int NSTAGE    = 4,
    parameter int PHASE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    adiabatic_pclk_seq_if.slave bus
);
    localparam int SUB_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam int PTR_W = $clog2(NSTAGE);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [1:0]        mp, mp_nxt, mp_inc;
    logic [SUB_W-1:0]  sub, sub_nxt;
    logic [PTR_W-1:0]  ptr, ptr_nxt;
    logic [NSTAGE-1:0] gate, gate_nxt;
    logic [NSTAGE-1:0] tok, tok_nxt;
    logic [1:0]        ph [NSTAGE];
    logic [1:0]        last_ph_nxt;
    logic              boundary;
    logic              in_ready_w;
    logic [NSTAGE-1:0] up_w, hold_w, dn_w;

    assign boundary    = (state != IDLE) && (sub == SUB_W'(PHASE_CYC - 1));
    assign mp_inc      = mp + 2'd1;
    assign last_ph_nxt = mp_inc - 2'(NSTAGE - 1);

    // Launch window: last cycle of the wave that ends with mp wrapping to EVAL.
    assign in_ready_w  = ((state == FILL) || (state == RUN)) && bus.en && boundary && (mp == 2'd3);

    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            ph[k]     = mp - 2'(k);
            up_w[k]   = gate[k] && (ph[k] == 2'd0);
            hold_w[k] = gate[k] && (ph[k] == 2'd1);
            dn_w[k]   = gate[k] && (ph[k] == 2'd2);
        end
    end

    always_comb begin
        state_nxt = state;
        mp_nxt    = mp;
        sub_nxt   = sub;
        ptr_nxt   = ptr;
        gate_nxt  = gate;
        tok_nxt   = tok;

        if (state == IDLE) begin
            if (bus.en) begin
                state_nxt   = FILL;
                mp_nxt      = 2'd0;
                sub_nxt     = '0;
                gate_nxt[0] = 1'b1;
                ptr_nxt     = PTR_W'(1);
            end
        end else begin
            sub_nxt = boundary ? '0 : sub + SUB_W'(1);
            if (boundary) begin
                mp_nxt = mp_inc;

                // Tokens advance when the receiving stage enters EVAL.
                for (int k = NSTAGE - 1; k >= 1; k--) begin
                    if (mp_inc == 2'(k)) begin
                        tok_nxt[k]   = tok[k-1];
                        tok_nxt[k-1] = 1'b0;
                    end
                end
                if (last_ph_nxt == 2'd2) tok_nxt[NSTAGE-1] = 1'b0;
                if (in_ready_w && bus.in_valid) tok_nxt[0] = 1'b1;

                case (state)
                    FILL: begin
                        gate_nxt[ptr] = 1'b1;
                        ptr_nxt       = ptr + PTR_W'(1);
                        if (ptr == PTR_W'(NSTAGE - 1)) begin
                            state_nxt = RUN;
                            ptr_nxt   = '0;
                        end
                    end
                    RUN: begin
                        if ((mp_inc == 2'd0) && !bus.en) begin
                            state_nxt   = DRAIN;
                            gate_nxt[0] = 1'b0;
                            ptr_nxt     = PTR_W'(1);
                        end
                    end
                    DRAIN: begin
                        gate_nxt[ptr] = 1'b0;
                        ptr_nxt       = ptr + PTR_W'(1);
                        if (ptr == PTR_W'(NSTAGE - 1)) begin
                            state_nxt = IDLE;
                            mp_nxt    = 2'd3;
                            sub_nxt   = '0;
                            ptr_nxt   = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mp    <= 2'd3;
            sub   <= '0;
            ptr   <= '0;
            gate  <= '0;
            tok   <= '0;
        end else begin
            state <= state_nxt;
            mp    <= mp_nxt;
            sub   <= sub_nxt;
            ptr   <= ptr_nxt;
            gate  <= gate_nxt;
            tok   <= tok_nxt;
        end
    end

    assign bus.pc_up     = up_w;
    assign bus.pc_hold   = hold_w;
    assign bus.pc_dn     = dn_w;
    assign bus.in_ready  = in_ready_w;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = gate[NSTAGE-1] && tok[NSTAGE-1] && (ph[NSTAGE-1] == 2'd1) && (sub == '0);

    mutex_a: assert property (@(posedge clk) disable iff (!rst_n)
        ((up_w & hold_w) | (up_w & dn_w) | (hold_w & dn_w)) == '0);
endmodule

// File: tb/tb_adiabatic_pclk_seq.sv
// Bench for the power-clock sequencer: time-based behavioural model checked
// every cycle, plus directed fill/token/drain/reset scenarios with literal values.
module tb_adiabatic_pclk_seq;
    localparam int NS = 4;
    localparam int PC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    adiabatic_pclk_seq_if #(.NSTAGE(NS)) bus();

    adiabatic_pclk_seq #(.NSTAGE(NS), .PHASE_CYC(PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a run starts at cycle t0, mp/subcount follow from elapsed time,
    // stage k is gated from t0+k*PC until dc+k*PC once a drain begins at dc.
    int mode = 0;   // 0 idle, 1 fill/run, 2 drain
    int t0 = 0;
    int dc = 0;
    int due[$];

    initial begin
        int c, e, mpv, ph;
        logic [NS-1:0] e_up, e_hold, e_dn;
        logic e_rdy, e_busy, e_ov;
        forever begin
            @(negedge clk);
            c = cyc;
            e = 0;
            if (!rst_n) begin
                mode = 0;
                due.delete();
            end else if (mode == 2 && c >= dc + (NS-1)*PC) begin
                mode = 0;
            end
            e_up = '0; e_hold = '0; e_dn = '0;
            e_rdy = 1'b0; e_busy = 1'b0;
            if (rst_n && mode != 0) begin
                e   = c - t0;
                mpv = (e / PC) % 4;
                for (int k = 0; k < NS; k++) begin
                    if (c >= t0 + k*PC && (mode != 2 || c < dc + k*PC)) begin
                        ph = ((mpv - k) % 4 + 4) % 4;
                        if (ph == 0) e_up[k] = 1'b1;
                        if (ph == 1) e_hold[k] = 1'b1;
                        if (ph == 2) e_dn[k] = 1'b1;
                    end
                end
                e_busy = 1'b1;
                e_rdy  = (mode == 1) && bus.en && (e % (4*PC) == 4*PC - 1);
            end
            e_ov = rst_n && (due.size() > 0) && (due[0] == c);
            check("model_pc_up",     int'(bus.pc_up),   int'(e_up));
            check("model_pc_hold",   int'(bus.pc_hold), int'(e_hold));
            check("model_pc_dn",     int'(bus.pc_dn),   int'(e_dn));
            check("model_in_ready",  int'(bus.in_ready), int'(e_rdy));
            check("model_out_valid", int'(bus.out_valid), int'(e_ov));
            check("model_busy",      int'(bus.busy),    int'(e_busy));
            while (due.size() > 0 && due[0] <= c) void'(due.pop_front());
            if (rst_n) begin
                if (mode == 0) begin
                    if (bus.en) begin
                        mode = 1;
                        t0   = c + 1;
                    end
                end else if (mode == 1) begin
                    if (e_rdy && bus.in_valid) due.push_back(c + NS*PC + 1);
                    if (c >= t0 + (NS-1)*PC && (e % (4*PC) == 4*PC - 1) && !bus.en) begin
                        mode = 2;
                        dc   = c + 1;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            check("rst_busy", int'(bus.busy), 0);
            check("rst_pc", int'({bus.pc_up, bus.pc_hold, bus.pc_dn}), 0);
            tick();
        end
    endtask

    initial begin
        logic en_r;
        bus.en = 1'b0;
        bus.in_valid = 1'b0;

        // Fill, single token at 16, ignored offer at 20, back-to-back at 32.
        do_reset();
        for (int n = 0; n <= 52; n++) begin
            bus.en = 1'b1;
            bus.in_valid = (n == 16 || n == 20 || n == 32);
            #3;
            if (n == 0)  check("fill_busy0", int'(bus.busy), 0);
            if (n == 1)  check("fill_up1", int'(bus.pc_up), 1);
            if (n == 4)  check("fill_up4", int'(bus.pc_up), 1);
            if (n == 5)  check("fill_up5", int'(bus.pc_up), 2);
            if (n == 5)  check("fill_hold5", int'(bus.pc_hold), 1);
            if (n == 9)  check("fill_dn9", int'(bus.pc_dn), 1);
            if (n == 9)  check("fill_up9", int'(bus.pc_up), 4);
            if (n == 13) check("fill_up13", int'(bus.pc_up), 8);
            if (n == 13) check("fill_dn13", int'(bus.pc_dn), 2);
            if (n == 15) check("rdy15", int'(bus.in_ready), 0);
            if (n == 16) check("rdy16", int'(bus.in_ready), 1);
            if (n == 20) check("rdy20", int'(bus.in_ready), 0);
            if (n == 32) check("rdy32", int'(bus.in_ready), 1);
            if (n == 48) check("rdy48", int'(bus.in_ready), 1);
            if (n == 32) check("ov32", int'(bus.out_valid), 0);
            if (n == 33) check("ov33", int'(bus.out_valid), 1);
            if (n == 34) check("ov34", int'(bus.out_valid), 0);
            if (n == 37) check("ov37", int'(bus.out_valid), 0);
            if (n == 49) check("ov49", int'(bus.out_valid), 1);
            tick();
        end

        // Drain with one token in flight; en re-raised during drain.
        do_reset();
        for (int n = 0; n <= 50; n++) begin
            bus.en = (n < 20) || (n >= 40);
            bus.in_valid = (n == 16);
            #3;
            if (n == 32) check("drn_rdy32", int'(bus.in_ready), 0);
            if (n == 33) check("drn_ov33", int'(bus.out_valid), 1);
            if (n == 33) check("drn_st0_33", int'({bus.pc_up[0], bus.pc_hold[0], bus.pc_dn[0]}), 0);
            if (n == 33) check("drn_hold33", int'(bus.pc_hold), 8);
            if (n == 44) check("drn_busy44", int'(bus.busy), 1);
            if (n == 45) check("drn_busy45", int'(bus.busy), 0);
            if (n == 45) check("drn_pc45", int'({bus.pc_up, bus.pc_hold, bus.pc_dn}), 0);
            if (n == 46) check("drn_up46", int'(bus.pc_up), 1);
            tick();
        end

        // Asynchronous reset in RUN, then a clean refill.
        do_reset();
        for (int n = 0; n <= 22; n++) begin
            bus.en = 1'b1;
            bus.in_valid = 1'b0;
            if (n == 22) begin
                #1;
                rst_n = 1'b0;
                #1;
                check("arst_pc", int'({bus.pc_up, bus.pc_hold, bus.pc_dn}), 0);
                check("arst_busy", int'(bus.busy), 0);
                check("arst_hs", int'({bus.in_ready, bus.out_valid}), 0);
            end
            tick();
        end
        tick();
        rst_n = 1'b1;
        for (int m = 0; m <= 17; m++) begin
            #3;
            if (m == 0)  check("refill_busy0", int'(bus.busy), 0);
            if (m == 1)  check("refill_up1", int'(bus.pc_up), 1);
            if (m == 5)  check("refill_up5", int'(bus.pc_up), 2);
            if (m == 13) check("refill_up13", int'(bus.pc_up), 8);
            if (m == 15) check("refill_rdy15", int'(bus.in_ready), 0);
            if (m == 16) check("refill_rdy16", int'(bus.in_ready), 1);
            tick();
        end

        // Randomised en / in_valid with occasional asynchronous resets.
        en_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) en_r = ~en_r;
            bus.en = en_r;
            bus.in_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 999) == 0) begin
                #1;
                rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
